// File: rtl/cla_pipe.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// Stage k adds slice k; upper operand bits and lower sums travel with each transaction.
module cla_pipe #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned BLOCK  = 4,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned S = WIDTH / STAGES;

    // Offset of stage k's forwarded-operand field in the flat operand store.
    function automatic int unsigned op_off(input int unsigned k);
        int unsigned o;
        o = 0;
        for (int unsigned j = 0; j < k; j++) begin
            o += WIDTH - (j + 1) * S;
        end
        return o;
    endfunction

    function automatic int unsigned sum_off(input int unsigned k);
        return S * k * (k + 1) / 2;
    endfunction

    // BLOCK-wide lookahead groups, group carries rippled; returns {carry_out, sum}.
    function automatic logic [S:0] cla_slice(input logic [S-1:0] x, input logic [S-1:0] y,
                                             input logic ci);
        logic [S-1:0] p;
        logic [S-1:0] g;
        logic [S-1:0] s;
        logic         cg;
        logic         gg;
        logic         pp;
        p  = x ^ y;
        g  = x & y;
        s  = '0;
        cg = ci;
        for (int unsigned grp = 0; grp < S / BLOCK; grp++) begin
            gg = 1'b0;
            pp = 1'b1;
            for (int unsigned i = 0; i < BLOCK; i++) begin
                s[grp*BLOCK+i] = p[grp*BLOCK+i] ^ (gg | (pp & cg));
                gg = g[grp*BLOCK+i] | (p[grp*BLOCK+i] & gg);
                pp = pp & p[grp*BLOCK+i];
            end
            cg = gg | (pp & cg);
        end
        return {cg, s};
    endfunction

    localparam int unsigned SumW  = sum_off(STAGES);
    localparam int unsigned OpW   = op_off(STAGES - 1);
    localparam int unsigned OpWq  = (OpW == 0) ? 1 : OpW;

    if (STAGES < 1 || WIDTH % STAGES != 0 || (WIDTH / STAGES) % BLOCK != 0) begin : g_param_err
        $error("cla_pipe: WIDTH must split into STAGES slices of whole BLOCK groups");
    end

    logic [STAGES-1:0] v_q, v_d, v_in, adv, load;
    logic [STAGES-1:0] c_q, c_d;
    logic [SumW-1:0]   sum_q, sum_d;
    logic [OpWq-1:0]   opa_q, opa_d, opb_q, opb_d;
    logic              ovf_q, ovf_d, zero_q, zero_d;

    logic [WIDTH-1:0]  b_prep;
    logic              c0;

    assign b_prep = op[0] ? ~b : b;
    assign c0     = op[1] ? cin : op[0];

    // Advance chain runs from the consumer back to the input.
    always_comb begin
        logic nxt;
        adv = '0;
        v_d = v_q;
        nxt = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            adv[k] = ~v_q[k] | nxt;
            nxt    = adv[k];
            v_d[k] = adv[k] ? v_in[k] : v_q[k];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned RemIn = WIDTH - k * S;

        logic [RemIn-1:0]     a_in, b_in;
        logic                 c_in;
        logic [S:0]           res;
        logic [(k+1)*S-1:0]   sum_new;

        assign res     = cla_slice(a_in[S-1:0], b_in[S-1:0], c_in);
        assign load[k] = adv[k] & v_in[k];
        assign c_d[k]  = load[k] ? res[S] : c_q[k];

        if (k == 0) begin : g_src
            assign a_in    = a;
            assign b_in    = b_prep;
            assign c_in    = c0;
            assign v_in[k] = in_valid;
            assign sum_new = res[S-1:0];
        end else begin : g_src
            assign a_in    = opa_q[op_off(k-1) +: RemIn];
            assign b_in    = opb_q[op_off(k-1) +: RemIn];
            assign c_in    = c_q[k-1];
            assign v_in[k] = v_q[k-1];
            assign sum_new = {res[S-1:0], sum_q[sum_off(k-1) +: k*S]};
        end

        assign sum_d[sum_off(k) +: (k+1)*S] =
            load[k] ? sum_new : sum_q[sum_off(k) +: (k+1)*S];

        if (k < STAGES - 1) begin : g_fwd
            localparam int unsigned RemOut = RemIn - S;
            assign opa_d[op_off(k) +: RemOut] =
                load[k] ? a_in[RemIn-1:S] : opa_q[op_off(k) +: RemOut];
            assign opb_d[op_off(k) +: RemOut] =
                load[k] ? b_in[RemIn-1:S] : opb_q[op_off(k) +: RemOut];
        end else begin : g_last
            logic msb_c;
            // Carry into the MSB recovered from the MSB sum bit.
            assign msb_c  = a_in[S-1] ^ b_in[S-1] ^ sum_new[WIDTH-1];
            assign ovf_d  = load[k] ? (msb_c ^ res[S]) : ovf_q;
            assign zero_d = load[k] ? ~|sum_new : zero_q;
        end
    end

    if (STAGES == 1) begin : g_no_fwd
        assign opa_d = '0;
        assign opb_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q    <= '0;
            c_q    <= '0;
            sum_q  <= '0;
            opa_q  <= '0;
            opb_q  <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            v_q    <= v_d;
            c_q    <= c_d;
            sum_q  <= sum_d;
            opa_q  <= opa_d;
            opb_q  <= opb_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = v_q[STAGES-1];
    assign result    = sum_q[sum_off(STAGES-1) +: WIDTH];
    assign cout      = c_q[STAGES-1];
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_cla_pipe.sv
// Directed bench for cla_pipe: default 32-bit/2-stage instance plus an 8-bit/4-stage instance.
module tb_cla_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, result;
    logic [1:0]  op;
    logic        cin, cout, ovf, zero;

    logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [7:0]  s_a, s_b, s_result;
    logic [1:0]  s_op;
    logic        s_cin, s_cout, s_ovf, s_zero;

    int checks;
    int failures;

    cla_pipe #(.WIDTH(32), .BLOCK(4), .STAGES(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .cout(cout), .ovf(ovf), .zero(zero)
    );

    cla_pipe #(.WIDTH(8), .BLOCK(2), .STAGES(4)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .a(s_a), .b(s_b), .op(s_op), .cin(s_cin), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .result(s_result), .cout(s_cout), .ovf(s_ovf), .zero(s_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one op to the empty 32-bit pipe and waits (bounded) for its result.
    task automatic send32(input logic [31:0] ta, input logic [31:0] tb, input logic [1:0] top,
                          input logic tc, output int lat, output logic [34:0] got);
        a = ta; b = tb; op = top; cin = tc; in_valid = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            lat++;
        end while (!out_valid && lat < 20);
        got = {result, cout, ovf, zero};
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        s_in_valid = 1'b0; s_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || {result, cout, ovf, zero} !== 35'h0) begin
            failures++;
            $display("FAIL reset_outputs: got valid=%b res=%h c=%b v=%b z=%b, want all 0",
                     out_valid, result, cout, ovf, zero);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        checks++;
        if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_small: got out_valid=%b in_ready=%b want 0/1",
                     s_out_valid, s_in_ready);
        end
    endtask

    // Shared table walker for the arithmetic directed vectors (ids select the test group).
    task automatic test_arith(input string tname, input int first, input int last);
        logic [31:0] ta, tb;
        logic [1:0]  top;
        logic        tc;
        logic [34:0] exp, got;
        int          lat;
        for (int i = first; i <= last; i++) begin
            case (i)
                0: begin ta = 32'hFFFF_FFFF; tb = 32'h1; top = 2'b00; tc = 1'b0;
                         exp = {32'h0, 1'b1, 1'b0, 1'b1}; end
                1: begin ta = 32'h0000_FFFF; tb = 32'h1; top = 2'b00; tc = 1'b0;
                         exp = {32'h0001_0000, 1'b0, 1'b0, 1'b0}; end
                2: begin ta = 32'h7FFF_FFFF; tb = 32'h1; top = 2'b00; tc = 1'b0;
                         exp = {32'h8000_0000, 1'b0, 1'b1, 1'b0}; end
                3: begin ta = 32'h1; tb = 32'h1; top = 2'b00; tc = 1'b1;
                         exp = {32'h2, 1'b0, 1'b0, 1'b0}; end
                4: begin ta = 32'h8000_0000; tb = 32'h1; top = 2'b01; tc = 1'b0;
                         exp = {32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0}; end
                5: begin ta = 32'h3; tb = 32'h5; top = 2'b01; tc = 1'b0;
                         exp = {32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0}; end
                6: begin ta = 32'h7; tb = 32'h2; top = 2'b01; tc = 1'b0;
                         exp = {32'h5, 1'b1, 1'b0, 1'b0}; end
                7: begin ta = 32'hFFFF_FFFF; tb = 32'h1; top = 2'b00; tc = 1'b0;
                         exp = {32'h0, 1'b1, 1'b0, 1'b1}; end
                8: begin ta = 32'h1; tb = 32'h2; top = 2'b10; tc = 1'b1;
                         exp = {32'h4, 1'b0, 1'b0, 1'b0}; end
                9: begin ta = 32'h5; tb = 32'h5; top = 2'b11; tc = 1'b0;
                         exp = {32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0}; end
                default: begin ta = 32'hA; tb = 32'h3; top = 2'b11; tc = 1'b1;
                         exp = {32'h7, 1'b1, 1'b0, 1'b0}; end
            endcase
            send32(ta, tb, top, tc, lat, got);
            checks++;
            if (lat != 2) begin
                failures++;
                $display("FAIL %s_latency[%0d]: got %0d want 2", tname, i, lat);
            end
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL %s[%0d]: got res=%h c=%b v=%b z=%b want res=%h c=%b v=%b z=%b",
                         tname, i, got[34:3], got[2], got[1], got[0],
                         exp[34:3], exp[2], exp[1], exp[0]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_q[$];
        logic [31:0] held;
        logic        stall_prev;
        int          sent, got, last_ret;
        sent = 0; got = 0; last_ret = -1; stall_prev = 1'b0; held = '0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(posedge clk); #1;
            if (stall_prev) begin
                checks++;
                if (out_valid !== 1'b1 || result !== held) begin
                    failures++;
                    $display("FAIL stall_stable[%0d]: got valid=%b res=%h want 1/%h",
                             cyc, out_valid, result, held);
                end
            end
            if (sent < 8) begin
                in_valid = 1'b1;
                a = 32'h0101_0101 * (sent + 1);
                b = 32'hF000_0000 + sent;
                op = 2'b00; cin = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            out_ready = !(cyc >= 3 && cyc <= 7);
            #2;
            if (cyc >= 3 && cyc <= 7) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL full_in_ready[%0d]: got %b want 0", cyc, in_ready);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_extra[%0d]: got res=%h want no result", cyc, result);
                end else begin
                    if (result !== exp_q[0]) begin
                        failures++;
                        $display("FAIL b2b_order[%0d]: got %h want %h", cyc, result, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
                if (last_ret >= 8) begin
                    checks++;
                    if (cyc - last_ret != 1) begin
                        failures++;
                        $display("FAIL b2b_throughput[%0d]: got gap %0d want 1",
                                 cyc, cyc - last_ret);
                    end
                end
                got++;
                last_ret = cyc;
            end
            stall_prev = out_valid && !out_ready;
            held = result;
            if (in_valid && in_ready) begin
                exp_q.push_back(a + b);
                sent++;
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++;
        if (got != 8 || sent != 8) begin
            failures++;
            $display("FAIL b2b_count: got retired=%0d accepted=%0d want 8/8", got, sent);
        end
    endtask

    task automatic test_reset_mid;
        int seen;
        out_ready = 1'b0;
        a = 32'h8000_0000; b = 32'h8000_0000; op = 2'b00; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || {result, cout, ovf, zero} !== {32'h0, 3'b111}
            || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL mid_prefill: got valid=%b res=%h c=%b v=%b z=%b rdy=%b want 1/0/1/1/1/0",
                     out_valid, result, cout, ovf, zero, in_ready);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || {result, cout, ovf, zero} !== 35'h0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset: got valid=%b res=%h c=%b v=%b z=%b rdy=%b want 0/0/0/0/0/1",
                     out_valid, result, cout, ovf, zero, in_ready);
        end
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL mid_dropped: got %0d results after reset want 0", seen);
        end
    endtask

    task automatic test_small_cfg;
        logic [10:0] exp, got;
        int          lat;
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: begin s_a = 8'hFF; s_b = 8'h01; s_op = 2'b00; s_cin = 1'b0;
                         exp = {8'h00, 3'b101}; end
                1: begin s_a = 8'h80; s_b = 8'h01; s_op = 2'b01; s_cin = 1'b0;
                         exp = {8'h7F, 3'b110}; end
                2: begin s_a = 8'h7F; s_b = 8'h00; s_op = 2'b10; s_cin = 1'b1;
                         exp = {8'h80, 3'b010}; end
                3: begin s_a = 8'h00; s_b = 8'h00; s_op = 2'b11; s_cin = 1'b0;
                         exp = {8'hFF, 3'b000}; end
                default: begin s_a = 8'h03; s_b = 8'h05; s_op = 2'b01; s_cin = 1'b0;
                         exp = {8'hFE, 3'b000}; end
            endcase
            s_in_valid = 1'b1;
            lat = 0;
            do begin
                @(posedge clk); #1;
                s_in_valid = 1'b0;
                lat++;
            end while (!s_out_valid && lat < 20);
            got = {s_result, s_cout, s_ovf, s_zero};
            checks++;
            if (lat != 4) begin
                failures++;
                $display("FAIL small_latency[%0d]: got %0d want 4", i, lat);
            end
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL small[%0d]: got res=%h cvz=%b want res=%h cvz=%b",
                         i, got[10:3], got[2:0], exp[10:3], exp[2:0]);
            end
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        a = '0; b = '0; op = '0; cin = 1'b0;
        s_a = '0; s_b = '0; s_op = '0; s_cin = 1'b0;
        test_reset();
        test_arith("add", 0, 3);
        test_arith("sub", 4, 6);
        test_arith("adc_sbc", 7, 10);
        test_back_to_back();
        test_reset_mid();
        test_small_cfg();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
